// File: rtl/data_memory_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_access_unit_pkg - funct3 load/store formats and FSM states.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package data_memory_access_unit_pkg;

  localparam logic [2:0] FMT_B  = 3'b000;
  localparam logic [2:0] FMT_H  = 3'b001;
  localparam logic [2:0] FMT_W  = 3'b010;
  localparam logic [2:0] FMT_BU = 3'b100;
  localparam logic [2:0] FMT_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Unsupported formats behave as W, so they share its alignment rule.
  function automatic logic is_misaligned(input logic [2:0] fmt, input logic [1:0] lo);
    case (fmt)
      FMT_B, FMT_BU: is_misaligned = 1'b0;
      FMT_H, FMT_HU: is_misaligned = lo[0];
      default:       is_misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_lane_align.sv
// ---------------------------------------------------------------------------
// data_memory_lane_align - byte enables, store replication, load extension.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_memory_lane_align
  import data_memory_access_unit_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] store_word_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = load_word_i[{addr_lo_i, 3'b000} +: 8];
  assign lane_h = load_word_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    byte_en_o    = 4'b1111;
    store_word_o = store_data_i;
    load_data_o  = load_word_i;
    case (fmt_i)
      FMT_B, FMT_BU: begin
        byte_en_o    = 4'b0001 << addr_lo_i;
        store_word_o = {4{store_data_i[7:0]}};
        load_data_o  = (fmt_i == FMT_B) ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
      end
      FMT_H, FMT_HU: begin
        byte_en_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        store_word_o = {2{store_data_i[15:0]}};
        load_data_o  = (fmt_i == FMT_H) ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_memory_access_unit.sv
// ---------------------------------------------------------------------------
// data_memory_access_unit - core load/store to data bus bridge with stall.
// MISALIGNED_TRAP_EN: trap misaligned H/W accesses without a bus cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_memory_access_unit
  import data_memory_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  data_format,
  input  logic [31:0] address,
  input  logic [31:0] write_data_in,
  output logic        stall,
  output logic [31:0] read_data_out,
  output logic        bus_error,
  output logic        misaligned_error,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic        bus_wait_req,
  input  logic        bus_valid,
  input  logic [31:0] bus_read_data
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  fmt_q;
  logic        write_q;
  logic [31:0] cnt_q;
  logic [31:0] rdata_q;
  logic        bus_err_q;

  logic        request;
  logic        timeout_hit;
  logic        issuing;
  logic [3:0]  byte_en;
  logic [31:0] store_word;
  logic [31:0] load_data;

  assign request     = mem_read | mem_write;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));
  assign issuing     = (state_q == ST_ISSUE);

  data_memory_lane_align u_align (
    .fmt_i        (fmt_q),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (wdata_q),
    .load_word_i  (bus_read_data),
    .byte_en_o    (byte_en),
    .store_word_o (store_word),
    .load_data_o  (load_data)
  );

`ifdef MISALIGNED_TRAP_EN
  logic mis_err_q;
  assign misaligned_error = mis_err_q;
`else
  assign misaligned_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      fmt_q     <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
`ifdef MISALIGNED_TRAP_EN
      mis_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (request) begin
            addr_q  <= address;
            fmt_q   <= data_format;
            write_q <= mem_write;
            wdata_q <= write_data_in;
            state_q <= ST_ISSUE;
`ifdef MISALIGNED_TRAP_EN
            if (is_misaligned(data_format, address[1:0])) begin
              mis_err_q <= 1'b1;
              state_q   <= ST_DONE;
            end
`endif
          end
        end
        ST_ISSUE: begin
          if (!bus_wait_req) begin
            if (write_q) begin
              state_q <= ST_DONE;
            end else if (bus_valid) begin
              rdata_q <= load_data;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Data arriving on the final allowed cycle beats the timeout.
          if (bus_valid) begin
            rdata_q <= load_data;
            state_q <= ST_DONE;
          end else if (timeout_hit) begin
            rdata_q   <= '0;
            bus_err_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          rdata_q   <= '0;
          bus_err_q <= 1'b0;
`ifdef MISALIGNED_TRAP_EN
          mis_err_q <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign stall            = (state_q == ST_IDLE) ? request : (state_q != ST_DONE);
  assign read_data_out    = rdata_q;
  assign bus_error        = bus_err_q;
  assign bus_read_enable  = issuing && !write_q;
  assign bus_write_enable = issuing && write_q;
  assign bus_address      = issuing ? {addr_q[31:2], 2'b00} : '0;
  assign bus_byte_enable  = issuing ? byte_en : '0;
  assign bus_write_data   = issuing ? store_word : '0;

endmodule

`default_nettype wire

// File: doc/data_memory_access_unit.md
Name: data_memory_access_unit

Overview:
- Sits between the core's memory stage and the data memory bus.
- Turns the core's load/store request (address, funct3 format, store data) into a bus transaction: byte enables, lane-replicated write data, read/write enables.
- Handles the bus wait_req/valid handshake and stalls the core until the access completes.
- Sign- or zero-extends load data for writeback.

Parameters:
- TIMEOUT, 255: max cycles in WAIT before aborting with bus_error; 0 disables the timeout.

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- mem_read  in  1  core load request
- mem_write  in  1  core store request
- data_format  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- address  in  32  byte address
- write_data_in  in  32  store data, value in low bits
- stall  out  1  core must hold its request and not advance
- read_data_out  out  32  extended load data, valid in DONE
- bus_error  out  1  timeout abort, pulses in DONE
- misaligned_error  out  1  see Optional Feature
- bus_address  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_write_data  out  32  lane-replicated store data
- bus_byte_enable  out  4  byte lanes
- bus_read_enable  out  1  read strobe
- bus_write_enable  out  1  write strobe
- bus_wait_req  in  1  bus not accepting this cycle
- bus_valid  in  1  read data valid
- bus_read_data  in  32  raw word from bus

Behaviour:
- Reset: async, state=IDLE; all outputs 0; timeout counter 0; request registers cleared. Reset mid-transaction drops the bus enables immediately; no completion.
- Request: mem_read|mem_write. If both are high, the write wins and it is treated as a store.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - stall = request.
  - On a request, register address, format, direction and store data; go to ISSUE.
- ISSUE:
  - stall=1. Enables are driven from the registers: bus_read_enable or bus_write_enable =1.
  - bus_wait_req=1: hold all bus outputs stable and stay.
  - bus_wait_req=0 and write: go to DONE.
  - bus_wait_req=0, read, and bus_valid the same cycle (zero-latency bus): capture data, go to DONE.
  - Otherwise (read, no valid yet): go to WAIT.
- WAIT:
  - stall=1; enables 0; timeout counter increments.
  - bus_valid: capture and extend data; go to DONE.
  - Counter reaches TIMEOUT (when TIMEOUT≠0): go to DONE with bus_error, read_data_out=0.
  - bus_valid and timeout in the same cycle: valid wins.
- DONE:
  - stall=0 for exactly one cycle; read_data_out, bus_error and misaligned_error are valid this cycle.
  - Core advances at the edge; next state IDLE. Counter is cleared.
  - Error outputs are 0 outside DONE.
- Minimum latency: 2 stall cycles (IDLE, ISSUE) + DONE.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
  - Loads assert the same lane enables.
- Write data: B = {4{d[7:0]}}, H = {2{d[15:0]}}, W = d.
- Load extension: select the lane by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU). W is passed through.
- Unsupported funct3 (011, 110, 111): treated as W.
- bus_valid outside WAIT/ISSUE-read: ignored.

Optional Feature:
- Macro: MISALIGNED_TRAP_EN.
- Defined:
  - Misaligned accesses: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - These issue no bus transaction. IDLE goes directly to DONE with misaligned_error=1 and read_data_out=0; stall is high for one cycle.
- Undefined:
  - misaligned_error is tied 0.
  - Offending low address bits are ignored (H uses addr[1] only; W uses lane 0), and the access proceeds normally.

Decomposition:
- Shared constants package: data_format encodings (FMT_B, FMT_H, FMT_W, FMT_BU, FMT_HU) and the FSM state enum.
- One natural combinational sub-module: data_memory_lane_align, which generates byte enables, replicates store data and extends load data. It is reused by the instruction-side checker.

Test Plan:
- SB addr 0x0000_1003, data 0xAB, no wait -> bus_byte_enable 4'b1000, bus_write_data 0xABABABAB, bus_address 0x0000_1000, stall high 2 cycles, DONE on cycle 3.
- LB addr 0x...1002, bus_read_data 0x0080_0000, valid same cycle as ISSUE -> read_data_out 0xFFFF_FF80. LBU with the same data -> 0x0000_0080.
- LW with bus_wait_req high 3 cycles, then valid 2 cycles later -> address and enables stable throughout ISSUE, stall 1+3+1+2 cycles, read_data_out = bus word.
- TIMEOUT=4, LW, bus_valid never asserted -> bus_error=1 for one cycle after 4 WAIT cycles, read_data_out 0, then IDLE.
- LH addr 0x...1001: with MISALIGNED_TRAP_EN -> no bus enables, misaligned_error=1 in DONE. Without it -> bus_byte_enable 4'b0011, normal completion.
- reset_n low during WAIT -> enables and stall 0 immediately. After release, state is IDLE; a stale bus_valid is ignored.
